prog_feeder: RTL

// - Upstream fetch stage of the 8-bit CPU. Holds a small program image and drives the CPU's byte input.
// - A host loads the image once over a valid/ready byte stream.
// - In run mode, each fetch strobe from the CPU selects an instruction slot by PC.
// - The slot's opcode byte is presented for one cycle, then its immediate byte is held until the next fetch.

---
 rtl/cpu_defs.sv | 15 +
 rtl/prog_feeder_mem.sv | 41 ++++
 rtl/prog_feeder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the 8-bit CPU front end: feeder state encodings and byte constants.
package cpu_defs;

   localparam int unsigned SLOT_W = 8;

   localparam logic [SLOT_W-1:0] OPC_NOP = 8'h00;

   typedef enum logic [1:0] {
      FEEDER_LOAD_IDLE = 2'd0,
      FEEDER_LOAD      = 2'd1,
      FEEDER_OP        = 2'd2,
      FEEDER_IMM       = 2'd3
   } feeder_state_e;

endpackage : cpu_defs

// File: rtl/prog_feeder_mem.sv
// Program image storage: flop array with synchronous write and registered read.
// The read register can be forced to a no-op so the CPU never sees stale or unloaded bytes.
module prog_feeder_mem
   import cpu_defs::*;
#(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [SLOT_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   input  logic              i_rd_zero,
   output logic [SLOT_W-1:0] o_rdata
);

   logic [SLOT_W-1:0] r_mem [DEPTH];
   logic [SLOT_W-1:0] r_rdata;

   // Image contents survive reset; only the host load rewrites them.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= OPC_NOP;
      end else if (i_rd_zero) begin
         r_rdata <= OPC_NOP;
      end else begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule : prog_feeder_mem

// File: rtl/prog_feeder.sv
// Fetch stage of the 8-bit CPU: host loads a program image, CPU fetches opcode/immediate pairs by PC.
// Build option PROG_FEEDER_CHECKSUM_EN adds output chk, the XOR of all bytes accepted in the current load.
module prog_feeder
   import cpu_defs::*;
#(
   parameter int unsigned SLOTS = 16,
   parameter int unsigned AW    = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_en,
   input  logic              load_valid,
   input  logic [SLOT_W-1:0] load_data,
   output logic              load_ready,
   input  logic [AW-1:0]     cpu_pc,
   input  logic              cpu_fetch,
   output logic [SLOT_W-1:0] cpu_byte,
   output logic [6:0]        prog_len,
   output logic              past_end
`ifdef PROG_FEEDER_CHECKSUM_EN
   ,output logic [SLOT_W-1:0] chk
`endif
);

   localparam int unsigned SW    = $clog2(SLOTS);
   localparam int unsigned MW    = SW + 1;
   localparam int unsigned PW    = SW + 2;
   localparam int unsigned CMPW  = (AW > 7) ? AW : 7;
   localparam logic [PW-1:0] DEPTH = PW'(2 * SLOTS);

   feeder_state_e   r_state;
   logic [PW-1:0]   r_wr_ptr;
   logic [6:0]      r_prog_len;
   logic            r_load_ready;
   logic            r_past_end;
   logic            r_fetch_q;
   logic            r_pend;
   logic [SW-1:0]   r_cur_slot;

   logic            w_run;
   logic            w_enter_load;
   logic            w_accept;
   logic [PW-1:0]   w_wr_ptr_inc;
   logic [PW-1:0]   w_wr_ptr_nxt;
   logic [6:0]      w_prog_len_nxt;
   logic            w_pc_ovf;
   logic            w_pc_past;
   logic [SW-1:0]   w_slot_sel;
   logic [MW-1:0]   w_rd_addr;
   logic            w_rd_zero;

   assign w_run        = (r_state == FEEDER_OP) || (r_state == FEEDER_IMM);
   assign w_enter_load = load_en && (r_state != FEEDER_LOAD);
   assign w_accept     = (r_state == FEEDER_LOAD) && r_load_ready && load_valid;

   assign w_wr_ptr_inc   = r_wr_ptr + PW'(1);
   assign w_wr_ptr_nxt   = w_accept ? w_wr_ptr_inc : r_wr_ptr;
   assign w_prog_len_nxt = 7'(w_wr_ptr_nxt >> 1);

   // PCs beyond the memory saturate onto the last slot; past_end masks them anyway.
   assign w_pc_ovf   = CMPW'(cpu_pc) >= CMPW'(SLOTS);
   assign w_pc_past  = CMPW'(cpu_pc) >= CMPW'(r_prog_len);
   assign w_slot_sel = w_pc_ovf ? SW'(SLOTS - 1) : cpu_pc[SW-1:0];

   assign w_rd_addr = {r_cur_slot, (r_state == FEEDER_IMM)};
   assign w_rd_zero = r_past_end || !w_run;

   // Feeder FSM with load pointers and the delayed fetch handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= FEEDER_LOAD_IDLE;
         r_wr_ptr     <= '0;
         r_prog_len   <= '0;
         r_load_ready <= 1'b0;
         r_past_end   <= 1'b1;
         r_fetch_q    <= 1'b0;
         r_pend       <= 1'b0;
         r_cur_slot   <= '0;
      end else begin
         r_fetch_q <= cpu_fetch && w_run && !load_en;
         if (w_enter_load) begin
            r_state      <= FEEDER_LOAD;
            r_wr_ptr     <= '0;
            r_prog_len   <= '0;
            r_load_ready <= 1'b1;
            r_past_end   <= 1'b1;
            r_pend       <= 1'b0;
         end else begin
            case (r_state)
               FEEDER_LOAD: begin
                  r_wr_ptr   <= w_wr_ptr_nxt;
                  r_prog_len <= w_prog_len_nxt;
                  if (!load_en) begin
                     r_state      <= FEEDER_OP;
                     r_cur_slot   <= '0;
                     r_past_end   <= (w_prog_len_nxt == 7'd0);
                     r_load_ready <= 1'b0;
                  end else begin
                     r_load_ready <= (w_wr_ptr_nxt < DEPTH);
                  end
               end
               FEEDER_OP: begin
                  r_state <= FEEDER_IMM;
                  if (r_fetch_q) begin
                     r_pend <= 1'b1;
                  end
               end
               FEEDER_IMM: begin
                  if (r_fetch_q || r_pend) begin
                     r_state    <= FEEDER_OP;
                     r_cur_slot <= w_slot_sel;
                     r_past_end <= w_pc_past;
                     r_pend     <= 1'b0;
                  end
               end
               default: begin
                  r_state <= FEEDER_LOAD_IDLE;
               end
            endcase
         end
      end
   end

`ifdef PROG_FEEDER_CHECKSUM_EN
   logic [SLOT_W-1:0] r_chk;

   // Running XOR over the bytes of the image currently being loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_chk <= '0;
      end else if (w_enter_load) begin
         r_chk <= '0;
      end else if (w_accept) begin
         r_chk <= r_chk ^ load_data;
      end
   end

   assign chk = r_chk;
`endif

   prog_feeder_mem #(
      .DEPTH  (2 * SLOTS),
      .ADDR_W (MW)
   ) u_mem (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (w_accept),
      .i_waddr   (r_wr_ptr[MW-1:0]),
      .i_wdata   (load_data),
      .i_raddr   (w_rd_addr),
      .i_rd_zero (w_rd_zero),
      .o_rdata   (cpu_byte)
   );

   assign load_ready = r_load_ready;
   assign prog_len   = r_prog_len;
   assign past_end   = r_past_end;

endmodule : prog_feeder
